pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush controller for the 5-stage MIPS pipeline.
//  - Drives the freeze and flush inputs of the IF/ID pipeline register and the PC: stall, loadForwardStall, superStall, Flush.
//  - Detects RAW hazards in ID, sequences multi-cycle SRAM waits in MEM and converts taken branches into wrong-path flushes.
//  - Also keeps a saturating stall-cycle counter and a sticky SRAM-timeout flag.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 10 +
 rtl/pipeline_hazard_ctrl_if.sv | 38 +++
 rtl/pipeline_hazard_ctrl_sram_fsm.sv | 55 +++++
 rtl/pipeline_hazard_ctrl.sv | 82 ++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Optional build macro FORWARD_EN selects the forwarding hazard policy (see top).
package pipeline_pkg;

  localparam int DEF_REG_W = 5;
  localparam int ZERO_REG  = 0;

  typedef enum logic {RUN, SRAM_WAIT} sram_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: stage operands in, stall/flush out.
interface pipeline_hazard_ctrl_if
  import pipeline_pkg::*;
#(
  parameter int REG_W = DEF_REG_W,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_two_src;
  logic [REG_W-1:0] exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_read;
  logic [REG_W-1:0] mem_dest;
  logic             mem_wb_en;
  logic             branch_taken;
  logic             mem_req;
  logic             sram_ready;
  logic             stall;
  logic             loadForwardStall;
  logic             superStall;
  logic             Flush;
  logic [CNT_W-1:0] stall_cycles;
  logic             sram_timeout;

  modport master (
    output id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, branch_taken, mem_req, sram_ready,
    input  stall, loadForwardStall, superStall, Flush, stall_cycles, sram_timeout
  );

  modport slave (
    input  id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, branch_taken, mem_req, sram_ready,
    output stall, loadForwardStall, superStall, Flush, stall_cycles, sram_timeout
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sram_fsm.sv
// SRAM wait sequencer: freezes the pipeline from mem_req until sram_ready or
// until SRAM_TMO wait cycles have elapsed.
module hazard_ctrl_sram_fsm
  import pipeline_pkg::*;
#(
  parameter int SRAM_TMO = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic sram_ready,
  output logic superStall,
  output logic timeout_hit
);

  localparam int WAIT_W = (SRAM_TMO > 2) ? $clog2(SRAM_TMO) : 1;

  sram_state_t       state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              at_limit;

  assign at_limit = (wait_cnt == WAIT_W'(SRAM_TMO - 1));

  // Outputs are gated by rst so everything reads 0 while reset is held.
  always_comb begin
    timeout_hit = rst & (state == SRAM_WAIT) & ~sram_ready & at_limit;
    superStall  = rst & (((state == RUN) & mem_req) |
                         ((state == SRAM_WAIT) & ~sram_ready & ~timeout_hit));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req) begin
            state    <= SRAM_WAIT;
            wait_cnt <= '0;
          end
        end
        SRAM_WAIT: begin
          if (sram_ready || at_limit) begin
            state <= RUN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Build macro FORWARD_EN: load-use stall only (forwarding); otherwise full RAW stall.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_W    = DEF_REG_W,
  parameter int CNT_W    = 16,
  parameter int SRAM_TMO = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  logic super_stall;
  logic timeout_hit;
  logic raw_exe;
  logic flush;
  logic stall_raw;
  logic load_stall;
  logic timeout_q;
  logic [CNT_W-1:0] cycle_cnt;

  function automatic logic reg_match(
    input logic             wb_en,
    input logic [REG_W-1:0] dest,
    input logic [REG_W-1:0] src1,
    input logic [REG_W-1:0] src2,
    input logic             two_src
  );
    return wb_en && (dest != REG_W'(ZERO_REG)) &&
           ((dest == src1) || (two_src && (dest == src2)));
  endfunction

  hazard_ctrl_sram_fsm #(
    .SRAM_TMO (SRAM_TMO)
  ) u_sram_fsm (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (hz.mem_req),
    .sram_ready  (hz.sram_ready),
    .superStall  (super_stall),
    .timeout_hit (timeout_hit)
  );

  // Priority: SRAM freeze, then wrong-path flush, then RAW stall.
  always_comb begin
    raw_exe    = reg_match(hz.exe_wb_en, hz.exe_dest, hz.id_src1, hz.id_src2, hz.id_two_src);
    flush      = rst & hz.branch_taken & ~super_stall;
    stall_raw  = 1'b0;
    load_stall = 1'b0;
`ifdef FORWARD_EN
    load_stall = rst & ~super_stall & ~flush & raw_exe & hz.exe_mem_read;
`else
    stall_raw  = rst & ~super_stall & ~flush &
                 (raw_exe | reg_match(hz.mem_wb_en, hz.mem_dest, hz.id_src1,
                                      hz.id_src2, hz.id_two_src));
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((stall_raw | load_stall | super_stall) && (cycle_cnt != '1)) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign hz.stall            = stall_raw;
  assign hz.loadForwardStall = load_stall;
  assign hz.superStall       = super_stall;
  assign hz.Flush            = flush;
  assign hz.stall_cycles     = cycle_cnt;
  assign hz.sram_timeout     = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: two controller instances (default and SRAM_TMO=4/CNT_W=3)
// driven identically and compared against a behavioural model every cycle.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] id_src1, id_src2, exe_dest, mem_dest;
  logic id_two_src, exe_wb_en, exe_mem_read, mem_wb_en, branch_taken, mem_req, sram_ready;

  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) bus_a ();
  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(3))  bus_b ();

  assign bus_a.id_src1 = id_src1;           assign bus_b.id_src1 = id_src1;
  assign bus_a.id_src2 = id_src2;           assign bus_b.id_src2 = id_src2;
  assign bus_a.id_two_src = id_two_src;     assign bus_b.id_two_src = id_two_src;
  assign bus_a.exe_dest = exe_dest;         assign bus_b.exe_dest = exe_dest;
  assign bus_a.exe_wb_en = exe_wb_en;       assign bus_b.exe_wb_en = exe_wb_en;
  assign bus_a.exe_mem_read = exe_mem_read; assign bus_b.exe_mem_read = exe_mem_read;
  assign bus_a.mem_dest = mem_dest;         assign bus_b.mem_dest = mem_dest;
  assign bus_a.mem_wb_en = mem_wb_en;       assign bus_b.mem_wb_en = mem_wb_en;
  assign bus_a.branch_taken = branch_taken; assign bus_b.branch_taken = branch_taken;
  assign bus_a.mem_req = mem_req;           assign bus_b.mem_req = mem_req;
  assign bus_a.sram_ready = sram_ready;     assign bus_b.sram_ready = sram_ready;

  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(16), .SRAM_TMO(64)) dut_a (
    .clk (clk), .rst (rst), .hz (bus_a.slave));
  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(3), .SRAM_TMO(4)) dut_b (
    .clk (clk), .rst (rst), .hz (bus_b.slave));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: per instance, whether an SRAM access is outstanding and
  // how many wait cycles it has already spent.
  int tmo[2]  = '{64, 4};
  int cmax[2] = '{65535, 7};
  bit m_busy[2];
  int m_waited[2];
  int m_cnt[2];
  bit m_tmo[2];

  typedef struct packed {
    logic st; logic lf; logic ss; logic fl; logic expire;
  } exp_t;

  function automatic logic uses(input logic en, input logic [4:0] d);
    return en && d != 0 && (d == id_src1 || (id_two_src && d == id_src2));
  endfunction

  function automatic exp_t expect_out(input int i);
    exp_t e;
    logic raw;
    e = '0;
    if (rst) begin
      e.expire = m_busy[i] && !sram_ready && (m_waited[i] + 1 == tmo[i]);
      e.ss = m_busy[i] ? (!sram_ready && !e.expire) : mem_req;
      e.fl = branch_taken && !e.ss;
`ifdef FORWARD_EN
      raw  = uses(exe_wb_en, exe_dest) && exe_mem_read;
      e.lf = raw && !e.ss && !e.fl;
`else
      raw  = uses(exe_wb_en, exe_dest) || uses(mem_wb_en, mem_dest);
      e.st = raw && !e.ss && !e.fl;
`endif
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_waited[i] = 0; m_cnt[i] = 0; m_tmo[i] = 0;
    end
  endtask

  task automatic model_update();
    exp_t e;
    if (!rst) return;
    for (int i = 0; i < 2; i++) begin
      e = expect_out(i);
      if (e.st || e.lf || e.ss) m_cnt[i] = (m_cnt[i] + 1 > cmax[i]) ? cmax[i] : m_cnt[i] + 1;
      if (!m_busy[i]) begin
        if (mem_req) begin m_busy[i] = 1; m_waited[i] = 0; end
      end else if (sram_ready || e.expire) begin
        m_busy[i] = 0;
        if (e.expire) m_tmo[i] = 1;
      end else begin
        m_waited[i]++;
      end
    end
  endtask

  task automatic compare_all();
    exp_t e;
    logic [5:0] got;
    logic [15:0] cnt;
    for (int i = 0; i < 2; i++) begin
      e   = expect_out(i);
      got = (i == 0) ? {bus_a.stall, bus_a.loadForwardStall, bus_a.superStall, bus_a.Flush, bus_a.sram_timeout, 1'b0}
                     : {bus_b.stall, bus_b.loadForwardStall, bus_b.superStall, bus_b.Flush, bus_b.sram_timeout, 1'b0};
      cnt = (i == 0) ? bus_a.stall_cycles : 16'(bus_b.stall_cycles);
      check($sformatf("stall%0d", i),        32'(got[5]), 32'(e.st));
      check($sformatf("ldfwd%0d", i),        32'(got[4]), 32'(e.lf));
      check($sformatf("superstall%0d", i),   32'(got[3]), 32'(e.ss));
      check($sformatf("flush%0d", i),        32'(got[2]), 32'(e.fl));
      check($sformatf("sram_timeout%0d", i), 32'(got[1]), 32'(m_tmo[i]));
      check($sformatf("stall_cycles%0d", i), 32'(cnt),    32'(m_cnt[i]));
    end
  endtask

  // Inputs change at negedge; step() samples mid-cycle, adv() crosses the edge.
  task automatic step();
    #1 compare_all();
    #1;
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin step(); adv(); end
  endtask

  task automatic clear_inputs();
    {id_src1, id_src2, exe_dest, mem_dest} = '0;
    {id_two_src, exe_wb_en, exe_mem_read, mem_wb_en, branch_taken, mem_req, sram_ready} = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    run(2);
    rst = 1'b1;
  endtask

  logic [4:0] ss_seq;

  initial begin
    clear_inputs();
    model_reset();
    @(negedge clk);
    mem_req = 1'b1;
    do_reset();
    mem_req = 1'b0;

    // SRAM access: one request cycle, three wait cycles, then ready.
    mem_req = 1'b1; step(); ss_seq[4] = bus_a.superStall; adv();
    mem_req = 1'b0;
    for (int k = 3; k >= 1; k--) begin step(); ss_seq[k] = bus_a.superStall; adv(); end
    sram_ready = 1'b1; step(); ss_seq[0] = bus_a.superStall; adv();
    sram_ready = 1'b0; step();
    check("sram_seq", 32'(ss_seq), 32'h1e);
    check("sram_cycles", 32'(bus_a.stall_cycles), 32'd4);
    check("sram_no_timeout", 32'(bus_a.sram_timeout), 32'd0);
    adv();

    // Branch held across an SRAM freeze with a concurrent load-use hazard.
    exe_dest = 5'd8; exe_mem_read = 1'b1; exe_wb_en = 1'b1; id_src1 = 5'd8;
    branch_taken = 1'b1; mem_req = 1'b1;
    step(); check("flush_frozen", 32'(bus_a.Flush), 32'd0); adv();
    mem_req = 1'b0;
    run(2);
    sram_ready = 1'b1; step();
    check("flush_ready", 32'(bus_a.Flush), 32'd1);
    check("ldfwd_under_flush", 32'(bus_a.loadForwardStall), 32'd0);
    adv();
    sram_ready = 1'b0; branch_taken = 1'b0;

    // Hazard compare: load-use on src1, register 0, MEM-stage src2.
    step();
`ifdef FORWARD_EN
    check("ldfwd_hit", 32'(bus_a.loadForwardStall), 32'd1);
`else
    check("raw_hit", 32'(bus_a.stall), 32'd1);
`endif
    adv();
    exe_dest = 5'd0; id_src1 = 5'd0; step();
    check("reg0_ldfwd", 32'(bus_a.loadForwardStall), 32'd0);
    check("reg0_stall", 32'(bus_a.stall), 32'd0);
    adv();
    exe_wb_en = 1'b0; exe_mem_read = 1'b0;
    mem_dest = 5'd9; mem_wb_en = 1'b1; id_two_src = 1'b1; id_src2 = 5'd9; id_src1 = 5'd3;
    run(1);
    id_two_src = 1'b0; run(1);
    clear_inputs();

    // Timeout on the small instance; then freeze until its counter saturates.
    mem_req = 1'b1; run(1); mem_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin step(); ss_seq[4-k] = bus_b.superStall; adv(); end
    step();
    check("tmo_seq", 32'(ss_seq[3:0]), 32'h1 << 1 | 32'h1 << 2 | 32'h1 << 3);
    check("tmo_flag", 32'(bus_b.sram_timeout), 32'd1);
    adv();
    mem_req = 1'b1; run(6); step();
    check("sat_cnt", 32'(bus_b.stall_cycles), 32'd7);
    check("tmo_sticky", 32'(bus_b.sram_timeout), 32'd1);
    adv();

    // Reset in the middle of a long SRAM wait (five wait cycles in).
    do_reset();
    mem_req = 1'b1; run(1); mem_req = 1'b0;
    run(5);
    mem_req = 1'b1; branch_taken = 1'b1;
    rst = 1'b0; model_reset(); step();
    check("rst_ss", 32'(bus_a.superStall), 32'd0);
    check("rst_flush", 32'(bus_a.Flush), 32'd0);
    check("rst_cnt", 32'(bus_a.stall_cycles), 32'd0);
    adv();
    rst = 1'b1; clear_inputs(); step();
    check("run_after_rst", 32'(bus_a.superStall), 32'd0);
    adv();

    // Randomized traffic over a small register set so hazards are frequent.
    for (int k = 0; k < 2000; k++) begin
      id_src1 = 5'($urandom_range(0, 3));  id_src2 = 5'($urandom_range(0, 3));
      exe_dest = 5'($urandom_range(0, 3)); mem_dest = 5'($urandom_range(0, 3));
      id_two_src = 1'($urandom_range(0, 1)); exe_wb_en = 1'($urandom_range(0, 1));
      exe_mem_read = 1'($urandom_range(0, 1)); mem_wb_en = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 5) == 0);
      mem_req = ($urandom_range(0, 7) == 0);
      sram_ready = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 199) != 0);
      if (!rst) model_reset();
      run(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
